// File: rtl/trace_pkg.sv
// Shared types for the commit-trace buffer: record layout, overflow policy
// and pointer sizing helpers.
package trace_pkg;

  // Record fields are sized for the widest supported core; narrower XLEN
  // values are zero-extended into pc/gprv.
  localparam int TRACE_XLEN = 64;
  localparam int DEF_DEPTH  = 64;
  localparam int PTR_W      = $clog2(DEF_DEPTH);

  typedef enum logic {
    OVF_DROP  = 1'b0,
    OVF_STALL = 1'b1
  } ovf_mode_e;

  typedef struct packed {
    logic [1:0]            level;
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           ir;
    logic                  gprw;
    logic [5:0]            gpra;
    logic [TRACE_XLEN-1:0] gprv;
    logic [63:0]           seq;
  } trace_rec_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/trace_compact.sv
// Lane compaction for sparse commits: exclusive prefix popcount gives each
// valid lane its slot offset from wr_ptr and its sequence increment; lanes
// whose offset reaches past the free space are not kept.
module trace_compact #(
  parameter int CW    = 4,
  parameter int OCC_W = 7,
  parameter int OFF_W = $clog2(CW + 1)
) (
  input  logic [CW-1:0]            valid,
  input  logic [OCC_W-1:0]         free,
  output logic [CW-1:0][OFF_W-1:0] offset,
  output logic [CW-1:0][OFF_W-1:0] seq_inc,
  output logic [CW-1:0]            keep,
  output logic [OFF_W-1:0]         total,
  output logic [OFF_W-1:0]         accepted
);

  logic [OFF_W-1:0] run;

  // Running count of valid lanes below each lane, in ascending lane order.
  always_comb begin
    run     = '0;
    offset  = '0;
    seq_inc = '0;
    keep    = '0;
    for (int i = 0; i < CW; i++) begin
      offset[i]  = run;
      seq_inc[i] = run;
      keep[i]    = valid[i] && (OCC_W'(run) < free);
      run        = run + OFF_W'(valid[i]);
    end
    total = run;
  end

  // Records actually stored this cycle: min(total, free).
  always_comb begin
    accepted = '0;
    if (OCC_W'(total) <= free) accepted = total;
    else                       accepted = OFF_W'(free);
  end

endmodule

// File: rtl/cmt_trace_buf.sv
// Commit-trace buffer: compacts up to CW sparse commit records per cycle into
// a DEPTH-entry circular store, tags each with a running sequence number and
// drains one record per cycle through a show-ahead valid/ready port.
// XLEN must not exceed trace_pkg::TRACE_XLEN.
module cmt_trace_buf
  import trace_pkg::*;
#(
  parameter  int CW       = 4,
  parameter  int DEPTH    = 64,
  parameter  int XLEN     = 64,
  parameter  int OVF_MODE = 0,
  localparam int PW       = ptr_width(DEPTH),
  localparam int OCC_W    = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [CW-1:0]            in_valid,
  input  logic [CW-1:0][1:0]       in_level,
  input  logic [CW-1:0][XLEN-1:0]  in_pc,
  input  logic [CW-1:0][31:0]      in_ir,
  input  logic [CW-1:0]            in_gprw,
  input  logic [CW-1:0][5:0]       in_gpra,
  input  logic [CW-1:0][XLEN-1:0]  in_gprv,
  output logic                     stall,
  output logic                     out_valid,
  input  logic                     out_ready,
  output trace_rec_t               out_rec,
  output logic [OCC_W-1:0]         occupancy,
  output logic [OCC_W-1:0]         hwm,
  output logic [63:0]              dropped,
  output logic [63:0]              seq_next
);

  localparam int        OFF_W = $clog2(CW + 1);
  localparam ovf_mode_e MODE  = (OVF_MODE != 0) ? OVF_STALL : OVF_DROP;

  trace_rec_t mem [DEPTH];

  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [OCC_W-1:0]         free;
  logic [OCC_W-1:0]         occ_next;
  logic                     pop;
  logic [CW-1:0][OFF_W-1:0] offset;
  logic [CW-1:0][OFF_W-1:0] seq_inc;
  logic [CW-1:0]            keep;
  logic [OFF_W-1:0]         total;
  logic [OFF_W-1:0]         accepted;
  trace_rec_t               lane_rec [CW];
  logic [PW-1:0]            wr_idx   [CW];

  // Free space comes from the registered occupancy only, so a same-cycle
  // pop never makes room for a push.
  assign free      = OCC_W'(DEPTH) - occupancy;
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;
  assign occ_next  = occupancy + OCC_W'(accepted) - OCC_W'(pop);
  assign out_rec   = mem[rd_ptr];

  trace_compact #(
    .CW    (CW),
    .OCC_W (OCC_W),
    .OFF_W (OFF_W)
  ) u_compact (
    .valid    (in_valid),
    .free     (free),
    .offset   (offset),
    .seq_inc  (seq_inc),
    .keep     (keep),
    .total    (total),
    .accepted (accepted)
  );

  // Assemble each lane's record and its target slot.
  always_comb begin
    for (int i = 0; i < CW; i++) begin
      lane_rec[i].level = in_level[i];
      lane_rec[i].pc    = TRACE_XLEN'(in_pc[i]);
      lane_rec[i].ir    = in_ir[i];
      lane_rec[i].gprw  = in_gprw[i];
      lane_rec[i].gpra  = in_gpra[i];
      lane_rec[i].gprv  = TRACE_XLEN'(in_gprv[i]);
      lane_rec[i].seq   = seq_next + 64'(seq_inc[i]);
      wr_idx[i]         = wr_ptr + PW'(offset[i]);
    end
  end

  // Storage is never read before being written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < CW; i++) begin
        if (keep[i]) mem[wr_idx[i]] <= lane_rec[i];
      end
    end
  end

  // Pointers, occupancy and accounting; flush clears the buffer but keeps
  // the sequence, drop and watermark history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      hwm       <= '0;
      dropped   <= '0;
      seq_next  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(accepted);
      rd_ptr    <= rd_ptr + PW'(pop);
      occupancy <= occ_next;
      seq_next  <= seq_next + 64'(total);
      dropped   <= dropped + 64'(total - accepted);
      if (occ_next > hwm) hwm <= occ_next;
    end
  end

  // Early back-pressure: assert while a full-width commit could not fit.
  always_comb begin
    stall = 1'b0;
    if (MODE == OVF_STALL) stall = (free < OCC_W'(CW));
  end

endmodule
